// File: rtl/sa_tile_sequencer.sv
// Job controller for the 16x16 systolic array: weight load, credit-gated activation issue, tagged result capture.
// Optional feature macro: SA_SEQ_PERF_EN (adds perf_busy_cycles / perf_stall_cycles counters).
module sa_tile_sequencer #(
  parameter int DATA_W     = 8,
  parameter int DATA_W_OUT = 32,
  parameter int SA_LAT     = 33,
  parameter int RES_DEPTH  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [15:0]             num_rows,
  input  logic                    transpose_cfg,
  output logic                    busy,
  output logic                    done,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [16*DATA_W-1:0]    w_data,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [16*DATA_W-1:0]    a_data,
  output logic [16*DATA_W-1:0]    sa_act_in,
  output logic [16*DATA_W-1:0]    sa_weight_in,
  output logic                    sa_load_w,
  output logic                    sa_transpose_en,
  input  logic [16*DATA_W_OUT-1:0] sa_psum_in,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic [16*DATA_W_OUT-1:0] r_data
`ifdef SA_SEQ_PERF_EN
  ,
  output logic [31:0]             perf_stall_cycles,
  output logic [31:0]             perf_busy_cycles
`endif
);
  localparam int PW = $clog2(RES_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_C  = (CW+1)'(RES_DEPTH);
  localparam logic [2:0]    S_IDLE   = 3'd0;
  localparam logic [2:0]    S_LOAD_W = 3'd1;
  localparam logic [2:0]    S_STREAM = 3'd2;
  localparam logic [2:0]    S_DRAIN  = 3'd3;
  localparam logic [2:0]    S_DONE   = 3'd4;

  logic [2:0]                state;
  logic [15:0]               rows_q;
  logic [15:0]               issue_cnt;
  logic [4:0]                w_cnt;
  logic                      tr_q;
  logic                      act_vld_q;
  logic [SA_LAT-1:0]         tag_sr;
  logic [CW-1:0]             inflight;
  logic [CW-1:0]             fifo_cnt;
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [16*DATA_W_OUT-1:0]  mem [RES_DEPTH];
  logic                      start_ok, w_hs, a_hs, push, pop;
  logic [CW:0]               credit_used;

  assign busy            = (state != S_IDLE);
  assign done            = (state == S_DONE);
  assign w_ready         = (state == S_LOAD_W);
  assign sa_transpose_en = busy && tr_q;
  assign start_ok        = (state == S_IDLE) && start;
  assign w_hs            = w_valid && w_ready;
  // Every issued row owns a FIFO slot until popped, so the array can never overrun us.
  assign credit_used     = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign a_ready         = (state == S_STREAM) && (credit_used < DEPTH_C);
  assign a_hs            = a_valid && a_ready;
  assign push            = tag_sr[SA_LAT-1];
  assign r_valid         = (fifo_cnt != '0);
  assign pop             = r_valid && r_ready;
  assign r_data          = r_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rows_q    <= '0;
      tr_q      <= 1'b0;
      w_cnt     <= '0;
      issue_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_ok) begin
          state     <= S_LOAD_W;
          rows_q    <= num_rows;
          tr_q      <= transpose_cfg;
          w_cnt     <= '0;
          issue_cnt <= '0;
        end
        S_LOAD_W: if (w_hs) begin
          w_cnt <= w_cnt + 5'd1;
          if (w_cnt == 5'd15) state <= (rows_q == '0) ? S_DRAIN : S_STREAM;
        end
        S_STREAM: if (a_hs) begin
          issue_cnt <= issue_cnt + 16'd1;
          if (issue_cnt + 16'd1 == rows_q) state <= S_DRAIN;
        end
        S_DRAIN: if (inflight == '0 && fifo_cnt == '0) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // act_vld_q marks the cycle a row sits on sa_act_in; the tap lines up with its deskewed psum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_load_w    <= 1'b0;
      sa_weight_in <= '0;
      sa_act_in    <= '0;
      act_vld_q    <= 1'b0;
      tag_sr       <= '0;
    end else begin
      sa_load_w <= w_hs;
      if (w_hs) sa_weight_in <= w_data;
      sa_act_in <= a_hs ? a_data : '0;
      act_vld_q <= a_hs;
      tag_sr    <= {tag_sr[SA_LAT-2:0], act_vld_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= inflight + CW'(a_hs) - CW'(push);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sa_psum_in;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_cnt == CW'(RES_DEPTH)));

`ifdef SA_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else if (start_ok) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy && perf_busy_cycles != '1) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (state == S_STREAM && a_valid && !a_ready && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: doc/sa_tile_sequencer.md
# sa_tile_sequencer

Job controller that feeds the 16x16 systolic-array top and collects its results. Per job it:
- loads one 16x16 weight tile through a ready/valid weight stream;
- streams activation rows from a ready/valid activation stream into the array;
- tags each issued row so the aligned partial-sum row returning from the array is captured into an internal result FIFO;
- drains the result FIFO to a ready/valid result stream.

It is the initiator the array top responds to. Credit-based issue guarantees no result is ever dropped, because the array itself cannot be back-pressured.

## Interface
Parameters:
- DATA_W, 8, activation/weight element width
- DATA_W_OUT, 32, partial-sum element width
- SA_LAT, 33, cycles from a row on sa_act_in to its deskewed row on sa_psum_in
- RES_DEPTH, 64, result FIFO depth in rows (must be > SA_LAT, power of 2)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job start pulse, honoured only in IDLE
- num_rows  in  16  activation rows in the job, sampled with start
- transpose_cfg  in  1  transpose mode, sampled with start
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at job end
- w_valid / w_ready  in / out  1  weight-row handshake
- w_data  in  16 x DATA_W  one weight row
- a_valid / a_ready  in / out  1  activation-row handshake
- a_data  in  16 x DATA_W  one activation row
- sa_act_in  out  16 x DATA_W  to array act_in, registered
- sa_weight_in  out  16 x DATA_W  to array weight_in, registered
- sa_load_w  out  1  to array load_w, registered
- sa_transpose_en  out  1  to array transpose_en
- sa_psum_in  in  16 x DATA_W_OUT  from array psum_out
- r_valid / r_ready  out / in  1  result-row handshake
- r_data  out  16 x DATA_W_OUT  FIFO head row

## Operation
States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- **IDLE:** start=1 latches num_rows and transpose_cfg, clears the weight and issue counters, and moves to LOAD_W. start in any other state is ignored.
- **LOAD_W:** w_ready=1.
  - Each w handshake registers w_data onto sa_weight_in with sa_load_w=1 for exactly one cycle; otherwise sa_load_w=0.
  - A 5-bit counter counts handshakes. The 16th handshake moves to STREAM, or to DRAIN if num_rows==0.
- **STREAM:** a_ready = (inflight + fifo_count < RES_DEPTH), where inflight is the number of issued rows not yet captured.
  - Each handshake registers a_data onto sa_act_in for one cycle; every non-issue cycle drives all-zero bubbles.
  - After num_rows handshakes, move to DRAIN.
- **DRAIN:** a_ready=0. Wait until inflight==0 and the FIFO is empty, then move to DONE.
- **DONE:** done=1 for one cycle, then IDLE.
- **Tagging:** an SA_LAT-deep valid shift register is loaded with 1 in each cycle a row is presented on sa_act_in. When the tap bit is 1, sa_psum_in is written to the FIFO at that edge.
- **Overflow rule:** the credit rule guarantees the FIFO is never written while full; a write while full is a design error and must be asserted against in simulation.
- **Result stream:** r_valid = FIFO not empty; pop on r_valid && r_ready. Simultaneous push and pop in one cycle leaves fifo_count unchanged. Pointers wrap modulo RES_DEPTH.
- **Mode hold:** sa_transpose_en = latched transpose_cfg for the whole job.

## Timing
- **Reset values:** all outputs 0 (busy, done, w_ready, a_ready, sa_load_w, sa_transpose_en, r_valid, all data buses), state IDLE, FIFO empty, counters and tag shift register cleared.
- **Reset mid-job** aborts immediately. In-flight array results returning later are not captured because the tags were cleared.
- **Start:** start in cycle c gives busy=1 and w_ready=1 in cycle c+1.
- **Weight path:** a weight handshake at edge k gives sa_load_w=1 and the row on sa_weight_in in cycle k+1.
- **Activation path:** an activation handshake at edge k puts the row on sa_act_in in cycle k+1. The matching sa_psum_in is sampled at the end of cycle k+1+SA_LAT; r_valid rises the following cycle at the earliest.
- **Throughput:** one row per cycle in STREAM when the result stream is unstalled.
- **Back-pressure:** a_ready is combinational from registered counters, with no dependence on a_valid.

## Configuration
SA_SEQ_PERF_EN:
- **Defined:** adds outputs perf_stall_cycles (32) and perf_busy_cycles (32).
  - perf_busy_cycles counts cycles with busy=1.
  - perf_stall_cycles counts STREAM cycles with a_valid=1 and a_ready=0.
  - Both clear on an accepted start, saturate at all-ones, and reset to 0.
- **Undefined:** these ports and counters do not exist.

## Test plan
- **Basic job:** reset, start with num_rows=4, 16 weight rows with w_valid always high, 4 activation rows, r_ready=1 → sa_load_w high exactly 16 consecutive cycles; 4 result rows equal to sa_psum_in sampled SA_LAT cycles after each issued row; done pulses once; busy falls in the same cycle done falls.
- **Empty job:** num_rows=0 → a_ready never 1; done follows the final weight load once the DRAIN conditions hold; no r_valid.
- **Result back-pressure:** num_rows=200, r_ready=0 → a_ready drops once inflight+fifo_count=64; exactly 64 rows are captured with no overflow. Then r_ready=1 → all 200 results arrive in issue order.
- **Bubbles:** a_valid toggling 1,0,0,1 → sa_act_in is zero on idle cycles and the tag register captures only the 2 issued rows.
- **Start and transpose:** start pulsed during STREAM → ignored, counters unchanged; transpose_cfg=1 holds sa_transpose_en=1 from LOAD_W through DONE.
- **Mid-job reset:** rst_n low during STREAM with 10 rows in flight → all outputs 0 next cycle; after release, no r_valid appears from the aborted job.
